decode_stage: RTL and testbench

Registered, parametrised successor to the single-format `control` decoder. It accepts one 32-bit RV32I instruction per cycle over a valid/ready handshake and decodes all base formats (R/I/S/B/U/J). It presents the decoded bundle one cycle later through a two-entry skid buffer. It sits between fetch and register-read/execute, and its `in_ready` is registered so fetch never sees a combinational path from execute stall.

---
 rtl/decode_pkg.sv | 64 ++++++
 rtl/instr_decoder.sv | 87 ++++++++
 rtl/decode_stage.sv | 141 ++++++++++++++
 tb/tb_decode_stage.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared RV32I decode definitions: opcodes, immediate selects, control bundle
// and skid-buffer state encoding.
package decode_pkg;

  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;

  localparam logic OP2_IMM = 1'b0;
  localparam logic OP2_RS2 = 1'b1;

  typedef enum logic [2:0] {
    IMM_I    = 3'd0,
    IMM_S    = 3'd1,
    IMM_B    = 3'd2,
    IMM_U    = 3'd3,
    IMM_J    = 3'd4,
    IMM_NONE = 3'd7
  } imm_sel_e;

  // XLEN-independent part of the decoded bundle; pc/imm are added per instance
  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;
    imm_sel_e   imm_sel;
    logic       op2_sel;
    logic       reg_write_en;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       use_pc;
    logic       illegal;
  } decode_ctrl_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_e;

  // 32-bit sign-extended immediate for a given format
  function automatic logic signed [31:0] imm32(input logic [31:0] instr, input imm_sel_e sel);
    logic signed [31:0] r;
    case (sel)
      IMM_S:   r = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   r = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   r = {instr[31:12], 12'b0};
      IMM_J:   r = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: r = {{20{instr[31]}}, instr[31:20]};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV32I base-format decoder: raw instruction + pc in,
// control bundle and XLEN-wide immediate out.
module instr_decoder
  import decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]      instr,
  input  logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  dec_pc,
  output logic [XLEN-1:0]  dec_imm,
  output decode_ctrl_t     dec_ctrl
);

  decode_ctrl_t ctrl;
  logic use_rd, use_rs1, use_rs2, use_f3, use_f7;

  assign dec_pc = pc;

  always_comb begin
    ctrl    = '0;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_f3  = 1'b0;
    use_f7  = 1'b0;
    if (instr[1:0] != 2'b11) begin
      ctrl.illegal = 1'b1;
    end else begin
      case (instr[6:0])
        OPC_OP_IMM: begin
          ctrl.imm_sel = IMM_I; ctrl.op2_sel = OP2_IMM; ctrl.reg_write_en = 1'b1;
          use_rd = 1'b1; use_rs1 = 1'b1; use_f3 = 1'b1;
        end
        OPC_OP: begin
          ctrl.imm_sel = IMM_NONE; ctrl.op2_sel = OP2_RS2; ctrl.reg_write_en = 1'b1;
          use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; use_f3 = 1'b1; use_f7 = 1'b1;
        end
        OPC_LOAD: begin
          ctrl.imm_sel = IMM_I; ctrl.mem_read = 1'b1; ctrl.reg_write_en = 1'b1;
          use_rd = 1'b1; use_rs1 = 1'b1; use_f3 = 1'b1;
        end
        OPC_STORE: begin
          ctrl.imm_sel = IMM_S; ctrl.mem_write = 1'b1;
          use_rs1 = 1'b1; use_rs2 = 1'b1; use_f3 = 1'b1;
        end
        OPC_BRANCH: begin
          ctrl.imm_sel = IMM_B; ctrl.op2_sel = OP2_RS2; ctrl.branch = 1'b1;
          use_rs1 = 1'b1; use_rs2 = 1'b1; use_f3 = 1'b1;
        end
        OPC_LUI: begin
          ctrl.imm_sel = IMM_U; ctrl.reg_write_en = 1'b1;
          use_rd = 1'b1;
        end
        OPC_AUIPC: begin
          ctrl.imm_sel = IMM_U; ctrl.use_pc = 1'b1; ctrl.reg_write_en = 1'b1;
          use_rd = 1'b1;
        end
        OPC_JAL: begin
          ctrl.imm_sel = IMM_J; ctrl.jump = 1'b1; ctrl.use_pc = 1'b1; ctrl.reg_write_en = 1'b1;
          use_rd = 1'b1;
        end
        OPC_JALR: begin
          ctrl.imm_sel = IMM_I; ctrl.jump = 1'b1; ctrl.reg_write_en = 1'b1;
          use_rd = 1'b1; use_rs1 = 1'b1; use_f3 = 1'b1;
        end
        default: ctrl.illegal = 1'b1;
      endcase
    end

    ctrl.rd     = use_rd  ? instr[11:7]  : 5'd0;
    ctrl.rs1    = use_rs1 ? instr[19:15] : 5'd0;
    ctrl.rs2    = use_rs2 ? instr[24:20] : 5'd0;
    ctrl.funct3 = use_f3  ? instr[14:12] : 3'd0;
    ctrl.funct7 = use_f7  ? instr[31:25] : 7'd0;
    // writes to x0 are architecturally discarded, so never request them
    ctrl.reg_write_en = ctrl.reg_write_en && (ctrl.rd != 5'd0);

    if (ctrl.illegal || (ctrl.imm_sel == IMM_NONE)) begin
      dec_imm = '0;
    end else begin
      dec_imm = XLEN'(imm32(instr, ctrl.imm_sel));
    end
    dec_ctrl = ctrl;
  end

endmodule

// File: rtl/decode_stage.sv
// Registered decode stage: instr_decoder feeding a two-entry FIFO skid buffer
// with a valid/ready handshake on both sides.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter bit          SKID_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       rd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [2:0]       funct3,
  output logic [6:0]       funct7,
  output logic [XLEN-1:0]  imm,
  output logic [2:0]       ImmSel,
  output logic             Op2Sel,
  output logic             RegWriteEn,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             Branch,
  output logic             Jump,
  output logic             UsePc,
  output logic             illegal
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    decode_ctrl_t    ctrl;
  } decoded_t;

  logic [XLEN-1:0] dec_pc, dec_imm;
  decode_ctrl_t    dec_ctrl;
  decoded_t        dec;

  buf_state_e state_q, state_d;
  decoded_t   head_q, head_d;
  decoded_t   tail_q, tail_d;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;
  logic       accept;

  instr_decoder #(.XLEN(XLEN)) u_instr_decoder (
    .instr    (in_instr),
    .pc       (in_pc),
    .dec_pc   (dec_pc),
    .dec_imm  (dec_imm),
    .dec_ctrl (dec_ctrl)
  );

  always_comb begin
    dec.pc   = dec_pc;
    dec.imm  = dec_imm;
    dec.ctrl = dec_ctrl;
  end

  // without the skid entry, ready must look through to the consumer
  assign in_ready = !rst && (SKID_EN ? in_ready_q : (!out_valid_q || out_ready));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    head_d      = head_q;
    tail_d      = tail_q;
    case (state_q)
      ST_EMPTY: begin
        if (accept) begin
          head_d  = dec;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (accept && out_ready) begin
          head_d = dec;
        end else if (accept) begin
          tail_d  = dec;
          state_d = ST_TWO;
        end else if (out_ready) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (out_ready) begin
          head_d  = tail_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
    end
    in_ready_d  = (state_d != ST_TWO);
    out_valid_d = (state_d != ST_EMPTY);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      head_q      <= '0;
      tail_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_pc     = head_q.pc;
  assign imm        = head_q.imm;
  assign rd         = head_q.ctrl.rd;
  assign rs1        = head_q.ctrl.rs1;
  assign rs2        = head_q.ctrl.rs2;
  assign funct3     = head_q.ctrl.funct3;
  assign funct7     = head_q.ctrl.funct7;
  assign ImmSel     = head_q.ctrl.imm_sel;
  assign Op2Sel     = head_q.ctrl.op2_sel;
  assign RegWriteEn = head_q.ctrl.reg_write_en;
  assign MemRead    = head_q.ctrl.mem_read;
  assign MemWrite   = head_q.ctrl.mem_write;
  assign Branch     = head_q.ctrl.branch;
  assign Jump       = head_q.ctrl.jump;
  assign UsePc      = head_q.ctrl.use_pc;
  assign illegal    = head_q.ctrl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: vector table through a scoreboard,
// plus back-pressure, flush and reset sequences.
module tb_decode_stage;

  localparam int NVEC = 14;

  logic        clk, rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, imm;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3, ImmSel;
  logic [6:0]  funct7;
  logic        Op2Sel, RegWriteEn, MemRead, MemWrite, Branch, Jump, UsePc, illegal;

  decode_stage #(.XLEN(32), .SKID_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3), .funct7(funct7),
    .imm(imm), .ImmSel(ImmSel), .Op2Sel(Op2Sel), .RegWriteEn(RegWriteEn),
    .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .Jump(Jump),
    .UsePc(UsePc), .illegal(illegal)
  );

  // flags = {Op2Sel, RegWriteEn, MemRead, MemWrite, Branch, Jump, UsePc, illegal}
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
    logic [2:0]  isel;
    logic [7:0]  flags;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    exp_t        e;
  } vec_t;

  vec_t vecs[NVEC];
  exp_t sb_q[$];
  exp_t cur_exp;
  exp_t ea, eb;
  int   tests, fails, pops, p0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  function automatic exp_t mk(input logic [4:0] r_d, input logic [4:0] r_s1, input logic [4:0] r_s2,
                              input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] im,
                              input logic [2:0] isel, input logic [7:0] fl);
    exp_t e;
    e.pc = 32'h0; e.rd = r_d; e.rs1 = r_s1; e.rs2 = r_s2; e.f3 = f3; e.f7 = f7;
    e.imm = im; e.isel = isel; e.flags = fl;
    return e;
  endfunction

  function automatic exp_t actual();
    exp_t e;
    e.pc = out_pc; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.f3 = funct3; e.f7 = funct7;
    e.imm = imm; e.isel = ImmSel;
    e.flags = {Op2Sel, RegWriteEn, MemRead, MemWrite, Branch, Jump, UsePc, illegal};
    return e;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // scoreboard runs at the falling edge, seeing what the next rising edge commits
  task automatic tick();
    @(negedge clk);
    if (rst || flush) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        pops++;
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL sb_unexpected: got output pc %h, expected no output", out_pc);
        end else begin
          check("sb_bundle", 128'(actual()), 128'(sb_q.pop_front()));
        end
      end
      if (in_valid && in_ready) sb_q.push_back(cur_exp);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int idx, input logic [31:0] pc);
    in_instr = vecs[idx].instr;
    in_pc    = pc;
    cur_exp  = vecs[idx].e;
    cur_exp.pc = pc;
    in_valid = 1'b1;
  endtask

  initial begin
    tests = 0; fails = 0; pops = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'h0; in_pc = 32'h0; cur_exp = '0;

    vecs[0]  = '{32'hFFF08293, mk(5'd5, 5'd1, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFF, 3'd0, 8'b0100_0000)};
    vecs[1]  = '{32'h0021A423, mk(5'd0, 5'd3, 5'd2, 3'd2, 7'h00, 32'h00000008, 3'd1, 8'b0001_0000)};
    vecs[2]  = '{32'hFE000EE3, mk(5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFFC, 3'd2, 8'b1000_1000)};
    vecs[3]  = '{32'h00000000, mk(5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 3'd0, 8'b0000_0001)};
    vecs[4]  = '{32'h00100013, mk(5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000001, 3'd0, 8'b0000_0000)};
    vecs[5]  = '{32'h402081B3, mk(5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'h00000000, 3'd7, 8'b1100_0000)};
    vecs[6]  = '{32'hFFC12303, mk(5'd6, 5'd2, 5'd0, 3'd2, 7'h00, 32'hFFFFFFFC, 3'd0, 8'b0110_0000)};
    vecs[7]  = '{32'h800003B7, mk(5'd7, 5'd0, 5'd0, 3'd0, 7'h00, 32'h80000000, 3'd3, 8'b0100_0000)};
    vecs[8]  = '{32'h12345417, mk(5'd8, 5'd0, 5'd0, 3'd0, 7'h00, 32'h12345000, 3'd3, 8'b0100_0010)};
    vecs[9]  = '{32'hFF9FF0EF, mk(5'd1, 5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFFFFF8, 3'd4, 8'b0100_0110)};
    vecs[10] = '{32'h00008067, mk(5'd0, 5'd1, 5'd0, 3'd0, 7'h00, 32'h00000000, 3'd0, 8'b0000_0100)};
    vecs[11] = '{32'h0000007F, mk(5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 3'd0, 8'b0000_0001)};
    vecs[12] = '{32'hFFF08290, mk(5'd0, 5'd0, 5'd0, 3'd0, 7'h00, 32'h00000000, 3'd0, 8'b0000_0001)};
    vecs[13] = '{32'hFE530FA3, mk(5'd0, 5'd6, 5'd5, 3'd0, 7'h00, 32'hFFFFFFFF, 3'd1, 8'b0001_0000)};

    // reset state
    tick(); tick();
    check("rst_in_ready", 128'(in_ready), 128'(1'b0));
    check("rst_out_valid", 128'(out_valid), 128'(1'b0));
    check("rst_bundle", 128'(actual()), 128'(0));
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 128'(in_ready), 128'(1'b1));
    check("post_rst_out_valid", 128'(out_valid), 128'(1'b0));

    // vector table streamed at full rate
    out_ready = 1'b1;
    p0 = pops;
    for (int i = 0; i < NVEC; i++) begin
      drive(i, 32'h1000 + 32'(i) * 32'd4);
      tick();
      check("stream_out_valid", 128'(out_valid), 128'(1'b1));
      check("stream_in_ready", 128'(in_ready), 128'(1'b1));
    end
    in_valid = 1'b0;
    tick(); tick();
    check("stream_count", 128'(pops - p0), 128'(NVEC));
    check("stream_idle", 128'(out_valid), 128'(1'b0));

    // back-pressure: two accepted, third waits, FIFO drain one per cycle
    out_ready = 1'b0;
    drive(0, 32'h2000); ea = cur_exp; tick();
    drive(1, 32'h2004); eb = cur_exp; tick();
    check("bp_in_ready_low", 128'(in_ready), 128'(1'b0));
    check("bp_head_a", 128'(actual()), 128'(ea));
    drive(2, 32'h2008); tick();
    check("bp_hold_a", 128'(actual()), 128'(ea));
    check("bp_hold_valid", 128'(out_valid), 128'(1'b1));
    tick();
    check("bp_still_a", 128'(actual()), 128'(ea));
    out_ready = 1'b1;
    p0 = pops;
    tick();
    check("bp_head_b", 128'(actual()), 128'(eb));
    tick();
    in_valid = 1'b0;
    tick();
    check("bp_drain_count", 128'(pops - p0), 128'(3));
    check("bp_empty", 128'(out_valid), 128'(1'b0));

    // flush in TWO with a same-cycle input
    out_ready = 1'b0;
    drive(5, 32'h3000); tick();
    drive(6, 32'h3004); tick();
    drive(7, 32'h3008); flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush2_out_valid", 128'(out_valid), 128'(1'b0));
    check("flush2_in_ready", 128'(in_ready), 128'(1'b1));
    out_ready = 1'b1; tick(); tick();

    // flush in ONE while the input would otherwise be accepted
    out_ready = 1'b0;
    drive(8, 32'h3100); tick();
    drive(9, 32'h3104); flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush1_out_valid", 128'(out_valid), 128'(1'b0));
    check("flush1_in_ready", 128'(in_ready), 128'(1'b1));
    out_ready = 1'b1; tick(); tick();

    // reset mid-operation in TWO, overriding a simultaneous flush
    out_ready = 1'b0;
    drive(10, 32'h4000); tick();
    drive(13, 32'h4004); tick();
    drive(3, 32'h4008); rst = 1'b1; flush = 1'b1; tick();
    check("rst_mid_in_ready", 128'(in_ready), 128'(1'b0));
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    #1;
    check("rst_mid_out_valid", 128'(out_valid), 128'(1'b0));
    check("rst_mid_in_ready_after", 128'(in_ready), 128'(1'b1));
    out_ready = 1'b1; tick(); tick();

    // normal traffic resumes after reset
    drive(1, 32'h5000); tick();
    in_valid = 1'b0; tick(); tick();
    check("sb_drained", 128'(sb_q.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
